stb_req_arb: RTL and testbench
==============================

Name: stb_req_arb

Overview:
- Responder side of the strobe request handshake (stb_req / stb_valid) for several skew-measurement controllers sharing one strobe generator.
- Accepts level requests from N_CH controller channels and grants them round-robin.
- Forwards one request at a time to the strobe generator and returns its stb_valid pulse to the granted channel only.
- Drives the channel-select code for the comparator/delay-line mux, and supervises the generator with a timeout.
- Sits in the strobe generator clock domain; requester-side synchronisation is done outside with sync_ff.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- TIMEOUT_CYCLES, 4096, cycles allowed in REQ for stb_valid_i before abort.
- CH_W, $clog2(N_CH), width of the channel index (derived, not overridable).

Ports:
- clk_i  in  1  strobe-domain clock
- arst_i  in  1  asynchronous active-high reset
- ch_stb_req_i  in  N_CH  per-channel request level, held until that channel's valid pulse
- ch_stb_valid_o  out  N_CH  per-channel one-cycle grant-complete pulse
- ch_sel_o  out  CH_W  index of the granted channel, drives the analog mux
- stb_req_o  out  1  request level to the strobe generator
- stb_valid_i  in  1  one-cycle pulse from the generator: strobe issued
- stb_rdy_i  in  1  generator locked on signal period
- stb_err_i  in  1  generator error level
- err_clr_i  in  1  one-cycle pulse, clears the sticky error
- busy_o  out  1  high in any state other than IDLE
- err_o  out  1  sticky abort flag
- err_ch_o  out  CH_W  channel being served at the last abort

Behaviour:
- Reset (arst_i high, async): state IDLE, rr pointer 0; all outputs 0 (ch_stb_valid_o, ch_sel_o, stb_req_o, busy_o, err_o, err_ch_o).
- FSM states: IDLE, SETUP, REQ, ACK, RELEASE.
- IDLE:
  - If stb_rdy_i && !stb_err_i && |ch_stb_req_i, pick the first asserted request at index >= ptr, wrapping modulo N_CH.
  - Register the index to ch_sel_o and go to SETUP.
  - ch_sel_o holds its last value while in IDLE.
- SETUP: exactly one cycle so the mux settles before the strobe request; then go to REQ.
- REQ:
  - stb_req_o = 1.
  - The timeout counter is cleared on entry and increments every cycle.
  - If stb_valid_i: stb_req_o drops on the next edge; go to ACK.
  - Else if stb_err_i, or counter == TIMEOUT_CYCLES-1: abort. Drop stb_req_o, set err_o = 1, err_ch_o = grant, ptr = grant+1 mod N_CH, go to IDLE. No valid pulse is issued.
  - stb_valid_i and abort in the same cycle: valid wins.
- ACK: ch_stb_valid_o[grant] = 1 for exactly one cycle (all other bits 0); go to RELEASE.
  - Latency: ch_stb_valid_o rises 2 cycles after stb_valid_i is sampled high.
- RELEASE: wait for ch_stb_req_i[grant] == 0; then ptr = grant+1 mod N_CH, go to IDLE.
  - Minimum gap: 1 cycle in IDLE between consecutive grants.
- Requester drops its request in SETUP or REQ: ignored. The transaction completes, the valid pulse is still issued, and RELEASE exits in one cycle.
- stb_valid_i outside REQ: ignored.
- stb_rdy_i falling during SETUP or REQ: no effect. Only stb_err_i or the timeout aborts.
- err_o is sticky; cleared only by err_clr_i or reset.
  - err_clr_i and a new abort in the same cycle: set wins.
  - err_o does not block new grants.
- Fairness: with all channels continuously requesting, grants cycle 0,1,..,N_CH-1,0.
- Timeout counter width is $clog2(TIMEOUT_CYCLES); it saturates and never wraps inside REQ.

Decomposition:
- Package skew_mes_pkg holds:
  - the state enum stb_arb_state_t {IDLE, SETUP, REQ, ACK, RELEASE};
  - the default TIMEOUT_CYCLES constant;
  - the shared strobe handshake description constants.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are the request vector and ptr; outputs are any_o and idx_o. It is reusable by future channel arbiters.
- The FSM, timeout counter and error logic stay in stb_req_arb.

Test Plan:
- Single channel (N_CH=4, req[2]=1, stb_rdy_i=1); generator model returns stb_valid_i 10 cycles after stb_req_o rises -> ch_sel_o=2 before stb_req_o; ch_stb_valid_o=4'b0100 for 1 cycle, exactly 2 cycles after stb_valid_i; busy_o low once req[2] drops.
- All four requests held, each re-asserted after its valid -> grant order 0,1,2,3,0,1; exactly one ch_stb_valid_o bit per transaction; stb_req_o never high in SETUP.
- Generator never answers, TIMEOUT_CYCLES=16, req[1]=1 -> stb_req_o high for exactly 16 cycles; err_o=1, err_ch_o=1, no valid pulse; next grant goes to channel 2 if it requests; err_clr_i clears err_o.
- stb_err_i rises 3 cycles into REQ for channel 3 -> abort next edge, err_ch_o=3; stb_rdy_i=0 or stb_err_i=1 in IDLE keeps requests ungranted and busy_o=0.
- stb_valid_i on the same cycle as the timeout limit -> ACK taken, err_o stays 0.
- arst_i pulsed mid-REQ -> all outputs 0 immediately (asynchronously); after release, grant restarts from channel 0; spurious stb_valid_i in IDLE produces no ch_stb_valid_o.

Source files
------------

// File: rtl/skew_mes_pkg.sv
// -----------------------------------------------------------------------------
// skew_mes_pkg
// Shared types and constants for the skew-measurement strobe path.
//   stb_arb_state_t      : strobe request arbiter FSM states
//   STB_TIMEOUT_DEFAULT  : default cycles the generator gets to answer a request
//   STB_*                : strobe handshake timing as seen by a requesting channel
// -----------------------------------------------------------------------------
package skew_mes_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        REQ     = 3'd2,
        ACK     = 3'd3,
        RELEASE = 3'd4
    } stb_arb_state_t;

    // Generator answer window before the arbiter aborts a request.
    localparam int unsigned STB_TIMEOUT_DEFAULT = 4096;

    // Cycles between grant and stb_req, letting the analog mux settle.
    localparam int unsigned STB_SETUP_CYCLES = 1;

    // Cycles from stb_valid sampled high to the channel valid pulse.
    localparam int unsigned STB_VALID_LATENCY = 2;

    // Minimum IDLE cycles between two consecutive grants.
    localparam int unsigned STB_MIN_GRANT_GAP = 1;

endpackage

// File: rtl/stb_req_arb_if.sv
// -----------------------------------------------------------------------------
// stb_req_arb_if
// Strobe generator handshake between the request arbiter and the generator.
//   stb_req   : request level, arbiter -> generator
//   stb_valid : one-cycle "strobe issued" pulse, generator -> arbiter
//   stb_rdy   : generator locked on the signal period
//   stb_err   : generator error level
// Modports: master = arbiter side, slave = generator side.
// -----------------------------------------------------------------------------
interface stb_req_arb_if;

    logic stb_req;
    logic stb_valid;
    logic stb_rdy;
    logic stb_err;

    modport master (
        output stb_req,
        input  stb_valid,
        input  stb_rdy,
        input  stb_err
    );

    modport slave (
        input  stb_req,
        output stb_valid,
        output stb_rdy,
        output stb_err
    );

endinterface

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first asserted request at an
// index >= ptr_i, wrapping modulo N.
//   req_i : request vector
//   ptr_i : highest-priority index (must be < N)
//   any_o : at least one request asserted
//   idx_o : chosen index (0 when any_o is low)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter  int unsigned N = 4,
    localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);

    always_comb begin
        logic        found;
        int unsigned cand;
        found = 1'b0;
        cand  = 0;
        idx_o = '0;
        for (int unsigned off = 0; off < N; off++) begin
            // ptr_i < N and off < N, so one subtraction is enough to wrap.
            cand = int'(ptr_i) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = W'(cand);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/stb_req_arb.sv
// -----------------------------------------------------------------------------
// stb_req_arb
// Round-robin arbiter letting several skew-measurement controllers share one
// strobe generator. One request is forwarded at a time; the generator's valid
// pulse is returned to the granted channel only, and the generator is
// supervised with a timeout.
//   clk_i          : strobe-domain clock
//   arst_i         : asynchronous active-high reset
//   gen_if         : strobe generator handshake (master side)
//   ch_stb_req_i   : per-channel request level, held until its valid pulse
//   ch_stb_valid_o : per-channel one-cycle grant-complete pulse
//   ch_sel_o       : granted channel index for the comparator/delay-line mux
//   err_clr_i      : one-cycle pulse clearing the sticky error
//   busy_o         : high in any state other than IDLE
//   err_o          : sticky abort flag
//   err_ch_o       : channel served at the last abort
// -----------------------------------------------------------------------------
module stb_req_arb
    import skew_mes_pkg::*;
#(
    parameter  int unsigned N_CH           = 4,
    parameter  int unsigned TIMEOUT_CYCLES = STB_TIMEOUT_DEFAULT,
    localparam int unsigned CH_W           = $clog2(N_CH)
) (
    input  logic                clk_i,
    input  logic                arst_i,
    stb_req_arb_if.master       gen_if,
    input  logic [N_CH-1:0]     ch_stb_req_i,
    output logic [N_CH-1:0]     ch_stb_valid_o,
    output logic [CH_W-1:0]     ch_sel_o,
    input  logic                err_clr_i,
    output logic                busy_o,
    output logic                err_o,
    output logic [CH_W-1:0]     err_ch_o
);

    localparam int unsigned   CntW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    stb_arb_state_t  state_q, state_d;
    logic [CH_W-1:0] grant_q, grant_d;
    logic [CH_W-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [CH_W-1:0] err_ch_q, err_ch_d;
    logic [N_CH-1:0] valid_q, valid_d;

    logic            pick_any;
    logic [CH_W-1:0] pick_idx;
    logic [CH_W-1:0] grant_inc;

    rr_pick #(
        .N (N_CH)
    ) u_rr_pick (
        .req_i (ch_stb_req_i),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign grant_inc = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + CH_W'(1);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        err_ch_d = err_ch_q;
        valid_d  = '0;

        // A clear is overridden below by an abort in the same cycle.
        if (err_clr_i) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (gen_if.stb_rdy && !gen_if.stb_err && pick_any) begin
                    grant_d = pick_idx;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                // Valid beats an abort raised in the same cycle.
                if (gen_if.stb_valid) begin
                    state_d = ACK;
                end else if (gen_if.stb_err || (cnt_q == CntMax)) begin
                    err_d    = 1'b1;
                    err_ch_d = grant_q;
                    ptr_d    = grant_inc;
                    state_d  = IDLE;
                end
            end
            ACK: begin
                // Registered so the channel sees it in the first RELEASE cycle.
                valid_d = N_CH'(1) << grant_q;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!ch_stb_req_i[grant_q]) begin
                    ptr_d   = grant_inc;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
            valid_q  <= valid_d;
        end
    end

    assign gen_if.stb_req = (state_q == REQ);
    assign ch_stb_valid_o = valid_q;
    assign ch_sel_o       = grant_q;
    assign busy_o         = (state_q != IDLE);
    assign err_o          = err_q;
    assign err_ch_o       = err_ch_q;

endmodule

// File: tb/tb_stb_req_arb.sv
// -----------------------------------------------------------------------------
// tb_stb_req_arb
// Directed bench for stb_req_arb with N_CH=4, TIMEOUT_CYCLES=16. Inputs change
// 1 time unit after the rising edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_stb_req_arb;

    localparam int unsigned NCh = 4;

    logic           clk;
    logic           arst;
    logic [NCh-1:0] req;
    logic [NCh-1:0] ch_valid;
    logic [1:0]     ch_sel;
    logic           err_clr;
    logic           busy;
    logic           err;
    logic [1:0]     err_ch;

    int n_chk  = 0;
    int n_pass = 0;

    stb_req_arb_if gen_if ();

    stb_req_arb #(
        .N_CH           (NCh),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk_i          (clk),
        .arst_i         (arst),
        .gen_if         (gen_if),
        .ch_stb_req_i   (req),
        .ch_stb_valid_o (ch_valid),
        .ch_sel_o       (ch_sel),
        .err_clr_i      (err_clr),
        .busy_o         (busy),
        .err_o          (err),
        .err_ch_o       (err_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        int n;
        n = 0;
        while (!busy && n < 8) begin
            tick();
            n++;
        end
        check("grant_seen", {31'd0, busy}, 32'd1);
    endtask

    // One full transaction: grant, REQ for lat cycles, valid, pulse, release.
    task automatic serve(input int ch, input int lat, input bit refill);
        logic [NCh-1:0] exp_vec;
        exp_vec = NCh'(1) << ch;
        wait_busy();
        check("setup_no_stb_req", {31'd0, gen_if.stb_req}, 32'd0);
        check("grant_ch", {30'd0, ch_sel}, ch);
        tick();
        check("stb_req_up", {31'd0, gen_if.stb_req}, 32'd1);
        repeat (lat) tick();
        gen_if.stb_valid = 1'b1;
        tick();
        gen_if.stb_valid = 1'b0;
        check("ack_cycle_quiet", {28'd0, ch_valid}, 32'd0);
        check("ack_stb_req_low", {31'd0, gen_if.stb_req}, 32'd0);
        tick();
        check("valid_vec", {28'd0, ch_valid}, {28'd0, exp_vec});
        tick();
        check("valid_one_cycle", {28'd0, ch_valid}, 32'd0);
        check("release_busy", {31'd0, busy}, 32'd1);
        req[ch] = 1'b0;
        tick();
        check("release_done", {31'd0, busy}, 32'd0);
        if (refill) req[ch] = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        logic [NCh-1:0] seen;

        arst             = 1'b1;
        req              = '0;
        err_clr          = 1'b0;
        gen_if.stb_valid = 1'b0;
        gen_if.stb_rdy   = 1'b0;
        gen_if.stb_err   = 1'b0;
        #2;
        check("reset_outputs", {24'd0, ch_valid, ch_sel, gen_if.stb_req, busy, err, err_ch}, 32'd0);
        tick();
        arst = 1'b0;

        // Single channel, generator answers 10 cycles after stb_req rises.
        gen_if.stb_rdy = 1'b1;
        req            = 4'b0100;
        serve(2, 10, 1'b0);

        // Fairness from a fresh pointer.
        arst = 1'b1;
        #2;
        arst = 1'b0;
        req = 4'b1111;
        serve(0, 2, 1'b1);
        serve(1, 3, 1'b1);
        serve(2, 1, 1'b1);
        serve(3, 4, 1'b1);
        serve(0, 2, 1'b1);
        serve(1, 5, 1'b1);

        // Generator never answers; pointer now at 2, only channel 1 requests.
        req = 4'b0010;
        wait_busy();
        check("to_grant_ch", {30'd0, ch_sel}, 32'd1);
        tick();
        n    = 0;
        seen = '0;
        while (gen_if.stb_req && n < 40) begin
            n++;
            seen |= ch_valid;
            tick();
        end
        check("to_req_cycles", n, 32'd16);
        check("to_no_valid", {28'd0, seen | ch_valid}, 32'd0);
        check("to_err", {31'd0, err}, 32'd1);
        check("to_err_ch", {30'd0, err_ch}, 32'd1);
        check("to_idle", {31'd0, busy}, 32'd0);
        req = 4'b0110;
        serve(2, 3, 1'b0);
        check("err_sticky", {31'd0, err}, 32'd1);
        check("err_ch_held", {30'd0, err_ch}, 32'd1);
        req     = '0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_cleared", {31'd0, err}, 32'd0);

        // Generator error 3 cycles into REQ for channel 3, clear in same cycle.
        req = 4'b1000;
        wait_busy();
        check("gerr_grant_ch", {30'd0, ch_sel}, 32'd3);
        tick();
        repeat (3) tick();
        gen_if.stb_err = 1'b1;
        err_clr        = 1'b1;
        check("gerr_req_before", {31'd0, gen_if.stb_req}, 32'd1);
        tick();
        err_clr = 1'b0;
        check("gerr_req_dropped", {31'd0, gen_if.stb_req}, 32'd0);
        check("gerr_set_wins", {31'd0, err}, 32'd1);
        check("gerr_err_ch", {30'd0, err_ch}, 32'd3);
        check("gerr_no_valid", {28'd0, ch_valid}, 32'd0);
        repeat (3) tick();
        check("idle_hold_on_err", {31'd0, busy}, 32'd0);
        gen_if.stb_err = 1'b0;
        gen_if.stb_rdy = 1'b0;
        repeat (3) tick();
        check("idle_hold_not_rdy", {31'd0, busy}, 32'd0);
        req            = '0;
        gen_if.stb_rdy = 1'b1;
        err_clr        = 1'b1;
        tick();
        err_clr = 1'b0;
        check("gerr_cleared", {31'd0, err}, 32'd0);

        // Valid on the same cycle as the timeout limit.
        req = 4'b0001;
        wait_busy();
        check("lim_grant_ch", {30'd0, ch_sel}, 32'd0);
        tick();
        repeat (15) tick();
        gen_if.stb_valid = 1'b1;
        check("lim_req_high", {31'd0, gen_if.stb_req}, 32'd1);
        tick();
        gen_if.stb_valid = 1'b0;
        check("lim_no_err", {31'd0, err}, 32'd0);
        check("lim_in_ack", {31'd0, busy}, 32'd1);
        tick();
        check("lim_valid", {28'd0, ch_valid}, 32'h1);
        req = '0;
        tick();
        check("lim_done", {31'd0, busy}, 32'd0);

        // Request dropped during SETUP: completes, RELEASE exits at once.
        req = 4'b0010;
        wait_busy();
        req = '0;
        tick();
        check("drop_req_high", {31'd0, gen_if.stb_req}, 32'd1);
        gen_if.stb_valid = 1'b1;
        tick();
        gen_if.stb_valid = 1'b0;
        tick();
        check("drop_valid", {28'd0, ch_valid}, 32'h2);
        tick();
        check("drop_release_fast", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-REQ; pointer would otherwise favour channel 3.
        req = 4'b0100;
        wait_busy();
        check("rst_grant_ch", {30'd0, ch_sel}, 32'd2);
        tick();
        #3;
        arst = 1'b1;
        #1;
        check("rst_async_outputs",
              {24'd0, ch_valid, ch_sel, gen_if.stb_req, busy, err, err_ch}, 32'd0);
        req = 4'b1111;
        #2;
        arst = 1'b0;
        tick();
        check("rst_restart_ch0", {30'd0, ch_sel}, 32'd0);
        check("rst_restart_busy", {31'd0, busy}, 32'd1);
        tick();
        gen_if.stb_valid = 1'b1;
        tick();
        gen_if.stb_valid = 1'b0;
        tick();
        check("rst_txn_valid", {28'd0, ch_valid}, 32'h1);
        req = '0;
        tick();

        // Spurious valid in IDLE.
        gen_if.stb_valid = 1'b1;
        tick();
        gen_if.stb_valid = 1'b0;
        seen = ch_valid;
        tick();
        seen |= ch_valid;
        tick();
        seen |= ch_valid;
        check("spurious_no_valid", {28'd0, seen}, 32'd0);
        check("spurious_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
